mult_job_scheduler: RTL and testbench

Arbitrating job sequencer in front of the AXI4-Lite multiplier slave. It accepts multiply jobs (operands `a`, `b`) from `NREQ` requesters and grants them round-robin. For each job it drives the AXI4-Lite master side: eight single-byte operand writes, then eight single-byte result reads. It returns the assembled `2*SZ`-bit product and an error flag to the granted requester.

---
 rtl/mult_sched_pkg.sv | 26 ++
 rtl/mult_job_scheduler_rr_arbiter.sv | 27 ++
 rtl/mult_job_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_mult_job_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiply job scheduler.
package mult_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_RESP
  } state_e;

  localparam int unsigned DEF_SZ    = 32;
  localparam int unsigned DEF_DSZ   = 8;
  localparam int unsigned DEF_NB    = DEF_SZ / DEF_DSZ;
  localparam int unsigned DEF_NXFER = 2 * DEF_NB;

  // AXI response encoding used by the slave: 1 means ok.
  localparam logic RESP_OK = 1'b1;

  function automatic int unsigned calc_nb(input int unsigned sz, input int unsigned dsz);
    return sz / dsz;
  endfunction

endpackage

// File: rtl/mult_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            any_o
);

  // Scan requesters starting at the pointer, wrapping, and take the first one.
  always_comb begin
    int unsigned idx;
    gnt_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < int'(NREQ); off++) begin
      idx = (32'(ptr_i) + off) % int'(NREQ);
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_job_scheduler.sv
// Arbitrating job sequencer in front of an AXI4-Lite multiplier slave.
// Optional handshake timeout: define MULT_SCHED_TIMEOUT_EN.
module mult_job_scheduler
  import mult_sched_pkg::*;
#(
  parameter int SZ   = int'(DEF_SZ),
  parameter int ASZ  = 4,
  parameter int DSZ  = int'(DEF_DSZ),
  parameter int NREQ = 2,
  parameter int TMO  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*SZ-1:0]  req_a,
  input  logic [NREQ*SZ-1:0]  req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [2*SZ-1:0]     rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic [ASZ-1:0]      awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DSZ-1:0]      wdata,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ASZ-1:0]      araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DSZ-1:0]      rdata,
  input  logic                rvalid,
  output logic                rready,
  input  logic                rresp
);

  localparam int unsigned NB = calc_nb(SZ, DSZ);
  localparam int unsigned NT = 2 * NB;
  localparam int          IW = (NT > 1) ? $clog2(NT) : 1;
  localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [2*SZ-1:0]     ops_q, ops_d;   // {b, a}: byte k of this vector is write address k
  logic [IW-1:0]       idx_q, idx_d;
  logic                err_q, err_d;
  logic [2*SZ-1:0]     data_q, data_d;

  logic [NREQ-1:0]     arb_gnt;
  logic                arb_any;
  logic [PW-1:0]       gidx;
  logic                last;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .any_o (arb_any)
  );

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_cfg;
  assign unused_cfg = |32'(TMO);
`endif

  // Next-state logic: grant in IDLE, then walk the 8 writes and 8 reads.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ops_d   = ops_q;
    idx_d   = idx_q;
    err_d   = err_q;
    data_d  = data_q;
    gidx    = '0;
    for (int unsigned i = 0; i < int'(NREQ); i++) begin
      if (arb_gnt[i]) gidx = PW'(i);
    end
    last = (idx_q == IW'(NT - 1));

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          ops_d   = {req_b[gidx*SZ +: SZ], req_a[gidx*SZ +: SZ]};
          ptr_d   = (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
          err_d   = 1'b0;
          idx_d   = '0;
          data_d  = '0;
          state_d = ST_AW;
        end
      end
      ST_AW: if (awready) state_d = ST_W;
      ST_W:  if (wready)  state_d = ST_B;
      ST_B: begin
        if (bvalid) begin
          err_d = err_q | (bresp != RESP_OK);
          if (last) begin
            idx_d   = '0;
            state_d = ST_AR;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_AW;
          end
        end
      end
      ST_AR: if (arready) state_d = ST_R;
      ST_R: begin
        if (rvalid) begin
          data_d[idx_q*DSZ +: DSZ] = rdata;
          err_d = err_q | (rresp != RESP_OK);
          if (last) begin
            state_d = ST_RESP;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_AR;
          end
        end
      end
      ST_RESP: begin
        if (|(rsp_ready & gnt_q)) begin
          gnt_d   = '0;
          err_d   = 1'b0;
          data_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef MULT_SCHED_TIMEOUT_EN
    // Timeout overrides whatever the handshake logic chose; counter restarts on any state change.
    tmo_d = '0;
    if (state_q inside {ST_AW, ST_W, ST_B, ST_AR, ST_R}) begin
      if (tmo_q == TW'(TMO - 1)) begin
        state_d = ST_RESP;
        err_d   = 1'b1;
        idx_d   = '0;
      end else if (state_d == state_q) begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ops_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ops_q   <= ops_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

`ifdef MULT_SCHED_TIMEOUT_EN
  // Handshake timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  // Acceptance pulse is combinational in IDLE; masked during reset so outputs read 0.
  assign req_ready = (state_q == ST_IDLE && !rst) ? arb_gnt : '0;
  assign rsp_valid = (state_q == ST_RESP) ? gnt_q  : '0;
  assign rsp_data  = (state_q == ST_RESP) ? data_q : '0;
  assign rsp_err   = (state_q == ST_RESP) ? err_q  : 1'b0;
  assign busy      = (state_q != ST_IDLE);
  assign awvalid   = (state_q == ST_AW);
  assign awaddr    = (state_q == ST_AW) ? ASZ'(idx_q) : '0;
  assign wvalid    = (state_q == ST_W);
  assign wdata     = (state_q == ST_W) ? ops_q[idx_q*DSZ +: DSZ] : '0;
  assign bready    = (state_q == ST_B);
  assign arvalid   = (state_q == ST_AR);
  assign araddr    = (state_q == ST_AR) ? ASZ'(idx_q) : '0;
  assign rready    = (state_q == ST_R);

endmodule

// File: tb/tb_mult_job_scheduler.sv
// Self-checking bench for mult_job_scheduler with a scoreboard of expected responses.
module tb_mult_job_scheduler;

  localparam int NREQ = 2;
`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int TB_TMO = 20;
`else
  localparam int TB_TMO = 255;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready, rsp_valid, rsp_ready;
  logic [63:0]       rsp_data;
  logic              rsp_err, busy;
  logic [3:0]        awaddr, araddr;
  logic              awvalid, awready, wvalid, wready, bresp, bvalid, bready;
  logic              arvalid, arready, rvalid, rready, rresp;
  logic [7:0]        wdata, rdata;

  mult_job_scheduler #(.SZ(32), .ASZ(4), .DSZ(8), .NREQ(NREQ), .TMO(TB_TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rresp(rresp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic        wready_en    = 1'b1;
  logic        bad_b_en     = 1'b0;
  logic        stall_en     = 1'b0;
  int          stall_base   = 0;
  int          ar_cyc       = 0;
  logic [3:0]  aw_lat       = '0;
  logic [3:0]  ar_lat       = '0;
  logic [63:0] ops_s        = '0;
  logic [63:0] prod_s;

  assign prod_s  = {32'b0, ops_s[31:0]} * {32'b0, ops_s[63:32]};
  assign awready = 1'b1;
  assign wready  = wready_en;
  assign bvalid  = 1'b1;
  assign bresp   = !(bad_b_en && aw_lat == 4'd2);
  assign arready = !(stall_en && (ar_cyc - stall_base) < 10);
  assign rvalid  = 1'b1;
  assign rresp   = 1'b1;
  assign rdata   = prod_s[ar_lat*8 +: 8];

  always @(posedge clk) begin
    if (awvalid && awready) aw_lat <= awaddr;
    if (wvalid && wready)   ops_s[aw_lat*8 +: 8] <= wdata;
    if (arvalid && arready) ar_lat <= araddr;
    if (arvalid)            ar_cyc <= ar_cyc + 1;
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct {
    int          who;
    logic [63:0] data;
    logic        err;
    bit          zw;
    bit          tmo;
  } exp_t;

  exp_t        sb[$];
  int          gseq[$];
  logic        rsp_ready_en = 1'b1;
  bit          zw_mode  = 1'b0;
  bit          tmo_mode = 1'b0;
  int          cyc = 0, t_rdy = 0, t_aw = 0, t_w = 0;
  int          ptr_m = 0, grants = 0, done_cnt = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, hold_cnt = 0;
  bit          aw_started = 0, rsp_seen = 0, ar_pend = 0, wv_prev = 0;
  logic [3:0]  ar_pend_addr = '0;
  logic [63:0] cur_ops = '0;

  assign rsp_ready = {NREQ{rsp_ready_en}};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      ptr_m = 0; sb.delete(); rsp_seen = 0; ar_pend = 0; aw_started = 0; wv_prev = 0;
    end else begin
      check_eq("overlap", $countones({awvalid, wvalid, bready, arvalid, rready}) <= 1, 1);
      if (ar_pend) begin
        check_eq("ar_hold", {arvalid, araddr}, {1'b1, ar_pend_addr});
        hold_cnt++;
      end
      ar_pend = arvalid && !arready;
      ar_pend_addr = araddr;
      if (awvalid && !aw_started) begin
        aw_started = 1;
        t_aw = cyc;
        check_eq("issue_lat", cyc - t_rdy, 1);
      end
      if (wvalid && !wv_prev) t_w = cyc;
      wv_prev = wvalid;
      if (awvalid && awready) begin check_eq("awaddr", awaddr, aw_cnt); aw_cnt++; end
      if (wvalid && wready)   begin check_eq("wdata", wdata, cur_ops[w_cnt*8 +: 8]); w_cnt++; end
      if (arvalid && arready) begin check_eq("araddr", araddr, ar_cnt); ar_cnt++; end
      if (req_ready != 0) begin
        int g;
        logic [NREQ-1:0] oh;
        exp_t e;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (ptr_m + k) % NREQ;
          if (req_valid[j] && g < 0) g = j;
        end
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        check_eq("grant", req_ready, oh);
        if (g < 0) g = 0;
        e.who  = g;
        e.data = tmo_mode ? 64'h0 : {32'b0, req_a[g*32 +: 32]} * {32'b0, req_b[g*32 +: 32]};
        e.err  = bad_b_en | tmo_mode;
        e.zw   = zw_mode;
        e.tmo  = tmo_mode;
        sb.push_back(e);
        gseq.push_back(g);
        cur_ops = {req_b[g*32 +: 32], req_a[g*32 +: 32]};
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_started = 0;
        ptr_m = (g + 1) % NREQ;
        t_rdy = cyc;
        grants++;
      end
      if (rsp_valid != 0 && !rsp_seen) begin
        rsp_seen = 1;
        if (sb.size() == 0) begin
          check_eq("spurious_rsp", rsp_valid, 0);
        end else begin
          exp_t e;
          logic [NREQ-1:0] oh;
          e = sb.pop_front();
          oh = '0;
          oh[e.who] = 1'b1;
          check_eq("rsp_who", rsp_valid, oh);
          check_eq("rsp_data", rsp_data, e.data);
          check_eq("rsp_err", rsp_err, e.err);
          if (e.zw)  check_eq("e2e_lat", cyc - t_aw, 40);
          if (e.tmo) check_eq("tmo_lat", cyc - t_w, TB_TMO);
          else       check_eq("xfers", {aw_cnt, ar_cnt}, {32'd8, 32'd8});
        end
        done_cnt++;
      end
      if ((rsp_valid & rsp_ready) != 0) rsp_seen = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] outs();
    return {37'b0, req_ready, rsp_valid, rsp_data, rsp_err, busy, awaddr, awvalid,
            wdata, wvalid, bready, araddr, arvalid, rready};
  endfunction

  task automatic apply_reset();
    @(posedge clk); #2 rst = 1'b1;
    #1 check_eq("rst_outs", outs(), 0);
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic drive_req(input int who, input logic [31:0] a, input logic [31:0] b);
    int g0, n;
    @(posedge clk); #1;
    req_a[who*32 +: 32] = a;
    req_b[who*32 +: 32] = b;
    req_valid[who] = 1'b1;
    g0 = grants;
    n = 0;
    while (grants == g0 && n < 300) begin @(posedge clk); n++; end
    check_eq("grant_wait", grants > g0, 1);
    #1 req_valid[who] = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 600) begin @(posedge clk); n++; end
    check_eq("done_wait", done_cnt >= target, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 600) begin @(posedge clk); n++; end
    check_eq("idle_wait", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_eq("reset_outs", outs(), 0);

    // Single job with a held-off response consumer.
    zw_mode = 1; rsp_ready_en = 1'b0;
    drive_req(0, 32'h0000_0003, 32'h0000_0005);
    wait_done(1);
    repeat (3) @(negedge clk);
    check_eq("rsp_hold", {rsp_valid, rsp_data, rsp_err, busy}, {2'b01, 64'hF, 1'b0, 1'b1});
    @(posedge clk); #1 rsp_ready_en = 1'b1;
    wait_idle();

    // Both requesters continuously valid: grants alternate from requester 0.
    apply_reset();
    gseq.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    req_a = {NREQ{32'hFFFF_FFFF}};
    req_b = {NREQ{32'hFFFF_FFFF}};
    req_valid = '1;
    n = 0;
    while (grants < 4 && gseq.size() < 4 && n < 800) begin @(posedge clk); n++; end
    while (gseq.size() < 4 && n < 800) begin @(posedge clk); n++; end
    #1 req_valid = '0;
    check_eq("rr_count", gseq.size(), 4);
    if (gseq.size() >= 4) check_eq("rr_order", {gseq[0], gseq[1], gseq[2], gseq[3]}, {32'd0, 32'd1, 32'd0, 32'd1});
    wait_done(d0 + 4);
    wait_idle();

    // AR stalled for 10 cycles.
    zw_mode = 0;
    stall_base = ar_cyc; stall_en = 1'b1;
    hold_cnt = 0;
    drive_req(1, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(done_cnt + 1);
    wait_idle();
    stall_en = 1'b0;
    check_eq("stall_seen", hold_cnt, 10);

    // Error response on write byte 2.
    bad_b_en = 1'b1;
    drive_req(0, 32'hDEAD_BEEF, 32'h0000_1001);
    wait_done(done_cnt + 1);
    wait_idle();
    bad_b_en = 1'b0;

    // Reset during write byte 5 aborts the job silently.
    drive_req(0, 32'h0000_0007, 32'h0000_0009);
    n = 0;
    while (!(awvalid && awaddr == 4'd5) && n < 200) begin @(negedge clk); n++; end
    check_eq("reach_byte5", awaddr, 5);
    apply_reset();
    d0 = done_cnt;
    repeat (60) @(posedge clk);
    check_eq("no_rsp_after_rst", done_cnt, d0);
    zw_mode = 1;
    drive_req(1, 32'h0001_0000, 32'h0001_0000);
    wait_done(d0 + 1);
    wait_idle();
    zw_mode = 0;

`ifdef MULT_SCHED_TIMEOUT_EN
    // Slave never accepts write data: timeout response.
    apply_reset();
    wready_en = 1'b0; tmo_mode = 1;
    drive_req(0, 32'h0000_0005, 32'h0000_0006);
    wait_done(done_cnt + 1);
    wait_idle();
    tmo_mode = 0;
    apply_reset();
    wready_en = 1'b1;
`endif

    check_eq("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
